// File: rtl/sysbr_pkg.sv
// sysbr_pkg - shared definitions for the system bridge data bus.
//
// Contents:
//   state_t   : sequencer state encoding for sysbr_arb
//   region_t  : address decode result (DM, IO, ERR)
//   DEF_*     : default memory map and IO timing, also used by the CPU-side
//               address decode so both agree on the window layout
//   in_window : 33-bit [base, base+size) membership test
//   decode    : maps a byte address onto a region; DM wins any overlap
package sysbr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DM_ACC,
        ST_IO_ACC,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        REG_DM,
        REG_IO,
        REG_ERR
    } region_t;

    localparam logic [31:0] DEF_DM_BASE_ADDR = 32'h0000_0000;
    localparam int unsigned DEF_DM_DEPTH     = 10;
    localparam logic [31:0] DEF_IO_BASE_ADDR = 32'h0000_7F00;
    localparam logic [31:0] DEF_IO_SIZE      = 32'h0000_0100;
    localparam int unsigned DEF_IO_WAIT      = 2;

    // Compares are done in 33 bits so that base + size never wraps past 2^32.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [32:0] size);
        logic [32:0] a;
        logic [32:0] lo;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        return (a >= lo) && (a < lo + size);
    endfunction

    function automatic region_t decode(input logic [31:0] addr,
                                       input logic [31:0] dm_base,
                                       input int unsigned dm_depth,
                                       input logic [31:0] io_base,
                                       input logic [31:0] io_size);
        logic [32:0] dm_size;
        dm_size = 33'd4 << dm_depth;
        if (in_window(addr, dm_base, dm_size)) begin
            return REG_DM;
        end else if (in_window(addr, io_base, {1'b0, io_size})) begin
            return REG_IO;
        end else begin
            return REG_ERR;
        end
    endfunction

endpackage

// File: rtl/sysbr_rr_arb2.sv
// sysbr_rr_arb2 - two-way round-robin pick with last-grant memory.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request from master 0 / master 1
//   adv        : commit the current pick (arbiter is sampling requests)
//   gnt_valid  : at least one request is present
//   gnt_id     : winning master (0 or 1)
//
// A lone requester always wins. On a tie the master not granted last wins.
// After reset last_grant is master 1, so master 0 wins the first tie.
module sysbr_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_q;

    always_comb begin
        gnt_valid = |req;
        if (&req) begin
            gnt_id = ~last_q;
        end else begin
            gnt_id = req[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (adv && gnt_valid) begin
            last_q <= gnt_id;
        end
    end

endmodule

// File: rtl/sysbr_arb.sv
// sysbr_arb - two-master arbiter and access sequencer for the bridge data bus.
//
// Master side (x = 0 CPU, x = 1 DMA/debug loader):
//   mx_req/wr/addr/wdata/be : request held until mx_ack
//   mx_ack                  : one-cycle completion pulse
//   mx_err                  : with ack, address hit no region
//   mx_rdata                : read data with ack, else 0
// Data memory side:
//   dm_wr, dm_addr (word), dm_din, dm_be : driven only in the DM access cycle
//   dm_dout                              : synchronous read data, 1-cycle latency
// IO side:
//   io_wr, io_rd, io_addr (byte), io_din : driven for IO_WAIT+1 cycles
//   io_dout                              : sampled on the last IO cycle
//
// Sequence: IDLE picks a master and latches its request, then DM_ACC (one
// cycle) or IO_ACC (IO_WAIT+1 cycles) or straight to RESP for an unmapped
// address. RESP returns the ack to the granted master, then back to IDLE.
// All target-side outputs are decoded from the state so an asynchronous
// reset drops every strobe immediately.
module sysbr_arb
    import sysbr_pkg::*;
#(
    parameter logic [31:0] DM_BASE_ADDR = DEF_DM_BASE_ADDR,
    parameter int unsigned DM_DEPTH     = DEF_DM_DEPTH,
    parameter logic [31:0] IO_BASE_ADDR = DEF_IO_BASE_ADDR,
    parameter logic [31:0] IO_SIZE      = DEF_IO_SIZE,
    parameter int unsigned IO_WAIT      = DEF_IO_WAIT
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_req,
    input  logic                m0_wr,
    input  logic [31:0]         m0_addr,
    input  logic [31:0]         m0_wdata,
    input  logic [3:0]          m0_be,
    output logic                m0_ack,
    output logic                m0_err,
    output logic [31:0]         m0_rdata,

    input  logic                m1_req,
    input  logic                m1_wr,
    input  logic [31:0]         m1_addr,
    input  logic [31:0]         m1_wdata,
    input  logic [3:0]          m1_be,
    output logic                m1_ack,
    output logic                m1_err,
    output logic [31:0]         m1_rdata,

    output logic                dm_wr,
    output logic [DM_DEPTH-1:0] dm_addr,
    output logic [31:0]         dm_din,
    output logic [3:0]          dm_be,
    input  logic [31:0]         dm_dout,

    output logic                io_wr,
    output logic                io_rd,
    output logic [31:0]         io_addr,
    output logic [31:0]         io_din,
    input  logic [31:0]         io_dout
);

    localparam int unsigned CNT_W = (IO_WAIT > 0) ? $clog2(IO_WAIT + 1) : 1;

    state_t            state_q;
    state_t            state_d;

    logic              gnt_valid;
    logic              gnt_id;
    logic              adv;

    logic              sel_wr;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_be;
    region_t           sel_region;

    logic              lat_wr;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_be;
    logic              lat_id;
    region_t           lat_region;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rdata_q;

    logic [31:0]       dm_off;
    logic              unused_dm_off_bits;
    logic [31:0]       resp_data;

    assign adv = (state_q == ST_IDLE);

    sysbr_rr_arb2 u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({m1_req, m0_req}),
        .adv       (adv),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Winner's request fields, only meaningful while sampling in IDLE.
    always_comb begin
        sel_wr     = gnt_id ? m1_wr    : m0_wr;
        sel_addr   = gnt_id ? m1_addr  : m0_addr;
        sel_wdata  = gnt_id ? m1_wdata : m0_wdata;
        sel_be     = gnt_id ? m1_be    : m0_be;
        sel_region = decode(sel_addr, DM_BASE_ADDR, DM_DEPTH, IO_BASE_ADDR, IO_SIZE);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    case (sel_region)
                        REG_DM:  state_d = ST_DM_ACC;
                        REG_IO:  state_d = ST_IO_ACC;
                        default: state_d = ST_RESP;
                    endcase
                end
            end
            ST_DM_ACC: state_d = ST_RESP;
            ST_IO_ACC: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lat_wr     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            lat_id     <= 1'b0;
            lat_region <= REG_ERR;
            cnt_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && gnt_valid) begin
                lat_wr     <= sel_wr;
                lat_addr   <= sel_addr;
                lat_wdata  <= sel_wdata;
                lat_be     <= sel_be;
                lat_id     <= gnt_id;
                lat_region <= sel_region;
                cnt_q      <= CNT_W'(IO_WAIT);
            end
            if (state_q == ST_IO_ACC) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    rdata_q <= io_dout;
                end
            end
        end
    end

    assign dm_off             = lat_addr - DM_BASE_ADDR;
    assign unused_dm_off_bits = ^{dm_off[31:DM_DEPTH+2], dm_off[1:0]};

    always_comb begin
        dm_wr    = 1'b0;
        dm_addr  = '0;
        dm_din   = '0;
        dm_be    = '0;
        io_wr    = 1'b0;
        io_rd    = 1'b0;
        io_addr  = '0;
        io_din   = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_rdata = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_rdata = '0;

        // DM read data arrives combinationally in RESP (one cycle after the
        // address); IO read data was captured on the last strobe cycle.
        if (lat_wr || lat_region == REG_ERR) begin
            resp_data = '0;
        end else if (lat_region == REG_DM) begin
            resp_data = dm_dout;
        end else begin
            resp_data = rdata_q;
        end

        case (state_q)
            ST_DM_ACC: begin
                dm_wr   = lat_wr;
                dm_addr = dm_off[DM_DEPTH+1:2];
                dm_din  = lat_wdata;
                dm_be   = lat_be;
            end
            ST_IO_ACC: begin
                io_wr   = lat_wr;
                io_rd   = ~lat_wr;
                io_addr = lat_addr;
                io_din  = lat_wdata;
            end
            ST_RESP: begin
                if (lat_id) begin
                    m1_ack   = 1'b1;
                    m1_err   = (lat_region == REG_ERR);
                    m1_rdata = resp_data;
                end else begin
                    m0_ack   = 1'b1;
                    m0_err   = (lat_region == REG_ERR);
                    m0_rdata = resp_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sysbr_arb.sv
module tb_sysbr_arb;

    localparam int IOW = 2;

    typedef struct packed {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        dm_wr;
        logic [9:0]  dm_addr;
        logic [31:0] dm_din;
        logic [3:0]  dm_be;
        logic        io_wr;
        logic        io_rd;
        logic [31:0] io_addr;
        logic [31:0] io_din;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;

    logic        drv_req   [2];
    logic        drv_wr    [2];
    logic [31:0] drv_addr  [2];
    logic [31:0] drv_wdata [2];
    logic [3:0]  drv_be    [2];

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        dm_wr;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic [3:0]  dm_be;
    logic [31:0] dm_dout;
    logic        io_wr, io_rd;
    logic [31:0] io_addr, io_din, io_dout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sysbr_arb #(
        .DM_BASE_ADDR (32'h0000_0000),
        .DM_DEPTH     (10),
        .IO_BASE_ADDR (32'h0000_7F00),
        .IO_SIZE      (32'h100),
        .IO_WAIT      (IOW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (drv_req[0]),
        .m0_wr    (drv_wr[0]),
        .m0_addr  (drv_addr[0]),
        .m0_wdata (drv_wdata[0]),
        .m0_be    (drv_be[0]),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m0_rdata (m0_rdata),
        .m1_req   (drv_req[1]),
        .m1_wr    (drv_wr[1]),
        .m1_addr  (drv_addr[1]),
        .m1_wdata (drv_wdata[1]),
        .m1_be    (drv_be[1]),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .m1_rdata (m1_rdata),
        .dm_wr    (dm_wr),
        .dm_addr  (dm_addr),
        .dm_din   (dm_din),
        .dm_be    (dm_be),
        .dm_dout  (dm_dout),
        .io_wr    (io_wr),
        .io_rd    (io_rd),
        .io_addr  (io_addr),
        .io_din   (io_din),
        .io_dout  (io_dout)
    );

    // Targets: synchronous DM (cleared by reset) and an IO device whose read
    // data is a cycle stamp, so the sampled cycle is visible in the result.
    logic [31:0] tmem [1024];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) tmem[i] <= '0;
            dm_dout <= '0;
        end else begin
            if (dm_wr)
                for (int b = 0; b < 4; b++)
                    if (dm_be[b]) tmem[dm_addr][8*b +: 8] <= dm_din[8*b +: 8];
            dm_dout <= tmem[dm_addr];
        end
    end
    assign io_dout = 32'hA500_0000 + 32'(cyc);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Transaction-level model: expected outputs are scheduled per cycle into a
    // small ring when a transfer starts, from the latency rules of each region.
    exp_t        ring [16];
    exp_t        e;
    logic [31:0] mmem [1024];
    int          busy_until = 0;
    int          last_g = 1;
    int          ack_m [$];
    int          ack_c [$];
    int          io_wr_cnt = 0, io_rd_cnt = 0;
    int          dm_wr_cyc = -1;
    logic [9:0]  dm_wr_addr = '0;

    task automatic schedule(input int t);
        int          w;
        longint      la;
        logic [31:0] a, rv;
        w  = (drv_req[0] && drv_req[1]) ? 1 - last_g : (drv_req[1] ? 1 : 0);
        last_g = w;
        a  = drv_addr[w];
        la = longint'(a);
        rv = '0;
        if (la < 4096) begin
            ring[(t+1)%16].dm_wr   = drv_wr[w];
            ring[(t+1)%16].dm_addr = a[11:2];
            ring[(t+1)%16].dm_din  = drv_wdata[w];
            ring[(t+1)%16].dm_be   = drv_be[w];
            if (drv_wr[w]) begin
                for (int b = 0; b < 4; b++)
                    if (drv_be[w][b]) mmem[a[11:2]][8*b +: 8] = drv_wdata[w][8*b +: 8];
            end else begin
                rv = mmem[a[11:2]];
            end
            ring[(t+2)%16].ack[w] = 1'b1;
            if (w == 1) ring[(t+2)%16].rd1 = rv; else ring[(t+2)%16].rd0 = rv;
            busy_until = t + 3;
        end else if (la >= 'h7F00 && la < 'h8000) begin
            for (int c = t + 1; c <= t + 1 + IOW; c++) begin
                ring[c%16].io_wr   = drv_wr[w];
                ring[c%16].io_rd   = !drv_wr[w];
                ring[c%16].io_addr = a;
                ring[c%16].io_din  = drv_wdata[w];
            end
            rv = drv_wr[w] ? 32'h0 : 32'hA500_0000 + 32'(t + 1 + IOW);
            ring[(t+2+IOW)%16].ack[w] = 1'b1;
            if (w == 1) ring[(t+2+IOW)%16].rd1 = rv; else ring[(t+2+IOW)%16].rd0 = rv;
            busy_until = t + 3 + IOW;
        end else begin
            ring[(t+1)%16].ack[w] = 1'b1;
            ring[(t+1)%16].err[w] = 1'b1;
            busy_until = t + 2;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ring[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 16; i++) ring[i] = '0;
                for (int i = 0; i < 1024; i++) mmem[i] = '0;
                busy_until = 0;
                last_g = 1;
            end
            e = ring[cyc%16];
            chk("m0_ack",   32'(m0_ack),   32'(e.ack[0]));
            chk("m0_err",   32'(m0_err),   32'(e.err[0]));
            chk("m0_rdata", m0_rdata,      e.rd0);
            chk("m1_ack",   32'(m1_ack),   32'(e.ack[1]));
            chk("m1_err",   32'(m1_err),   32'(e.err[1]));
            chk("m1_rdata", m1_rdata,      e.rd1);
            chk("dm_wr",    32'(dm_wr),    32'(e.dm_wr));
            chk("dm_addr",  32'(dm_addr),  32'(e.dm_addr));
            chk("dm_din",   dm_din,        e.dm_din);
            chk("dm_be",    32'(dm_be),    32'(e.dm_be));
            chk("io_wr",    32'(io_wr),    32'(e.io_wr));
            chk("io_rd",    32'(io_rd),    32'(e.io_rd));
            chk("io_addr",  io_addr,       e.io_addr);
            chk("io_din",   io_din,        e.io_din);
            ring[cyc%16] = '0;
            if (m0_ack) begin ack_m.push_back(0); ack_c.push_back(cyc); end
            if (m1_ack) begin ack_m.push_back(1); ack_c.push_back(cyc); end
            if (io_wr) io_wr_cnt++;
            if (io_rd) io_rd_cnt++;
            if (dm_wr) begin dm_wr_cyc = cyc; dm_wr_addr = dm_addr; end
            if (rst_n && cyc >= busy_until && (drv_req[0] || drv_req[1]))
                schedule(cyc);
        end
    end

    task automatic access(input int m, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be, input bit hold,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int start);
        bit got;
        @(posedge clk); #1;
        drv_req[m] = 1'b1; drv_wr[m] = wr; drv_addr[m] = a;
        drv_wdata[m] = d; drv_be[m] = be;
        start = cyc; got = 1'b0; rd = '0; er = 1'b0; lat = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ack : m1_ack) begin
                got = 1'b1;
                lat = cyc - start;
                rd  = (m == 0) ? m0_rdata : m1_rdata;
                er  = (m == 0) ? m0_err : m1_err;
            end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL ack_timeout m%0d addr %h: got no ack expected ack within 20 cycles", m, a);
        end
        if (!hold) begin
            @(posedge clk); #1;
            drv_req[m] = 1'b0;
        end
    endtask

    typedef struct { logic [31:0] addr; int lat; logic err; } bnd_t;
    bnd_t bnd [8] = '{
        '{32'h0000_0FFC, 2, 1'b0}, '{32'h0000_1000, 1, 1'b1},
        '{32'h0000_7EFC, 1, 1'b1}, '{32'h0000_7F00, 4, 1'b0},
        '{32'h0000_7FFC, 4, 1'b0}, '{32'h0000_8000, 1, 1'b1},
        '{32'hFFFF_FFFC, 1, 1'b1}, '{32'h0001_0000, 1, 1'b1}
    };

    initial begin
        logic [31:0] rd, rd1;
        logic        er, er1;
        int          lat, lat1, st, st1;
        bit          seen;

        for (int m = 0; m < 2; m++) begin
            drv_req[m] = 1'b0; drv_wr[m] = 1'b0; drv_addr[m] = '0;
            drv_wdata[m] = '0; drv_be[m] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_m0_ack", 32'(m0_ack), 32'h0);
        chk("reset_dm_wr",  32'(dm_wr),  32'h0);

        // DM write then read back
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, er, lat, st);
        chk("wr_lat",        32'(lat),        32'd2);
        chk("wr_strobe_cyc", 32'(dm_wr_cyc),  32'(st + 1));
        chk("wr_dm_addr",    32'(dm_wr_addr), 32'd4);
        access(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, er, lat, st);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_lat",  32'(lat), 32'd2);

        // Partial write, read back by the other master
        access(0, 1'b1, 32'h14, 32'h12345678, 4'b0011, 1'b0, rd, er, lat, st);
        access(1, 1'b0, 32'h14, 32'h0, 4'hF, 1'b0, rd, er, lat, st);
        chk("be_rd_data", rd, 32'h0000_5678);

        // Both masters streaming reads: last grant was m1, so m0 leads
        ack_m.delete(); ack_c.delete();
        fork
            begin
                for (int i = 0; i < 3; i++)
                    access(0, 1'b0, 32'h10, 32'h0, 4'hF, i < 2, rd, er, lat, st);
            end
            begin
                for (int i = 0; i < 3; i++)
                    access(1, 1'b0, 32'h14, 32'h0, 4'hF, i < 2, rd1, er1, lat1, st1);
            end
        join
        chk("rr_ack_count", 32'(ack_m.size()), 32'd6);
        for (int i = 0; i < 6 && i < ack_m.size(); i++) begin
            chk("rr_order", 32'(ack_m[i]), 32'(i % 2));
            if (i > 0) chk("rr_spacing", 32'(ack_c[i] - ack_c[i-1]), 32'd3);
        end

        // IO write and read with two wait states
        io_wr_cnt = 0; io_rd_cnt = 0;
        access(1, 1'b1, 32'h7F04, 32'hCAFE_0001, 4'hF, 1'b0, rd, er, lat, st);
        chk("io_wr_lat",    32'(lat),       32'd4);
        chk("io_wr_cycles", 32'(io_wr_cnt), 32'd3);
        access(1, 1'b0, 32'h7F08, 32'h0, 4'hF, 1'b0, rd, er, lat, st);
        chk("io_rd_cycles", 32'(io_rd_cnt), 32'd3);
        chk("io_rd_data",   rd, 32'hA500_0000 + 32'(st + 3));

        // Decode boundaries and unmapped addresses
        foreach (bnd[i]) begin
            access(0, 1'b0, bnd[i].addr, 32'h0, 4'hF, 1'b0, rd, er, lat, st);
            chk("bnd_lat", 32'(lat), 32'(bnd[i].lat));
            chk("bnd_err", 32'(er),  32'(bnd[i].err));
            if (bnd[i].err) chk("bnd_err_rdata", rd, 32'h0);
        end

        // Reset in the middle of an IO access
        @(posedge clk); #1;
        drv_req[0] = 1'b1; drv_wr[0] = 1'b1; drv_addr[0] = 32'h7F10;
        drv_wdata[0] = 32'h1111_2222; drv_be[0] = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = io_wr;
        end
        chk("io_abort_started", 32'(seen), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0; drv_req[0] = 1'b0;
        @(negedge clk);
        chk("io_abort_io_wr",  32'(io_wr),  32'h0);
        chk("io_abort_m0_ack", 32'(m0_ack), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ack_m.delete(); ack_c.delete();
        fork
            access(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, er, lat, st);
            access(1, 1'b0, 32'h14, 32'h0, 4'hF, 1'b0, rd1, er1, lat1, st1);
        join
        chk("post_reset_first", (ack_m.size() > 0) ? 32'(ack_m[0]) : 32'hFFFF_FFFF, 32'd0);
        chk("post_reset_rdata", rd, 32'h0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1);
    end

endmodule

// File: doc/sysbr_arb.md
# sysbr_arb

Two-master arbiter and sequencer for the system bridge data bus. It sits between the pipeline's memory stage (master 0, CPU) and a secondary bus master (master 1, DMA/debug loader) on one side, and the data memory and IO unit on the other. It grants one master at a time with round-robin fairness and decodes the address into DM or IO. It sequences the access, including programmable IO wait states, and returns a single-cycle acknowledge with read data.

## Interface
- DM_BASE_ADDR, 32'h0000_0000, first byte address of data memory
- DM_DEPTH, 10, DM word-address width; DM spans 4·2^DM_DEPTH bytes
- IO_BASE_ADDR, 32'h0000_7F00, first byte address of IO window
- IO_SIZE, 32'h100, IO window size in bytes
- IO_WAIT, 2, extra wait cycles per IO access (0 allowed)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  access request; held until the matching ack
- m0_wr / m1_wr  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_be / m1_be  in  4  byte enables
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  valid with ack; address decoded to no region
- m0_rdata / m1_rdata  out  32  read data, valid with ack, else 0
- dm_wr  out  1  DM write strobe
- dm_addr  out  DM_DEPTH  DM word address, (addr − DM_BASE_ADDR)[DM_DEPTH+1:2]
- dm_din / dm_be  out  32 / 4  DM write data / byte enables
- dm_dout  in  32  DM read data (synchronous, one-cycle latency)
- io_wr / io_rd  out  1  IO write / read strobes
- io_addr  out  32  IO byte address (full address, passed through)
- io_din  out  32  IO write data
- io_dout  in  32  IO read data, sampled on the last IO cycle

## Operation
- FSM states: IDLE, DM_ACC, IO_ACC, RESP.
- IDLE: if any req, pick a winner. Single requester wins. On a tie, the master not granted last wins. Latch wr, addr, wdata, be, master id, and region. Update last_grant.
- Decode: DM if DM_BASE_ADDR ≤ addr < DM_BASE_ADDR + 4·2^DM_DEPTH. Else IO if IO_BASE_ADDR ≤ addr < IO_BASE_ADDR + IO_SIZE. Else ERR. DM wins any overlap. Use 33-bit compares so upper bounds never wrap.
- DM target → DM_ACC. IO target → IO_ACC with wait counter = IO_WAIT. ERR → RESP directly with err set, no strobes, rdata 0.
- DM_ACC: one cycle. dm_wr = latched wr. Address, data, and be driven. → RESP.
- IO_ACC: io_wr or io_rd held high while counter > 0. The counter decrements each cycle. At counter = 0, capture io_dout into the response register → RESP. Strobes are high for IO_WAIT+1 cycles.
- RESP: the granted master's ack = 1. rdata = captured read data, or dm_dout for a DM read. rdata = 0 for writes and errors. → IDLE.
- The ungranted master's ack, err, and rdata stay 0. A request from the ungranted master waits, stalled by the absence of ack.
- Outputs to DM/IO are 0 outside their access states; there are no stray strobes.

## Timing
- Reset values: state IDLE, all acks/errs 0, all rdata 0, dm_wr/io_wr/io_rd 0, addresses/data 0, last_grant = master 1 (master 0 wins the first tie). Reset may assert in any state. It aborts the access immediately with no ack, and a pending write may or may not have reached the target.
- DM access: req high in cycle n → DM strobe in cycle n+1 → ack in cycle n+2.
- IO access: req cycle n → strobes in cycles n+1 … n+1+IO_WAIT → ack in cycle n+2+IO_WAIT.
- Error: req cycle n → ack+err in cycle n+1.
- Masters must drop or change req in the cycle after ack. The arbiter returns to IDLE after RESP and samples req again in the cycle after ack. Minimum spacing is 3 cycles per DM access.
- Requests are sampled only in IDLE. Changes to address or data while waiting are ignored once latched.

## Structure
- Shared package sysbr_pkg holds:
  - the state encoding
  - the region enum (DM, IO, ERR)
  - the default base/size constants, also used by the CPU-side address decode
- Sub-module sysbr_rr_arb2 (2-way round-robin pick plus last_grant register) is instantiated once.
- Address decode stays inline as combinational functions from the package.

## Test plan
- Reset, then m0 write 32'hDEADBEEF to 0x0000_0010, be=4'hF → dm_wr in cycle n+1 with dm_addr=4, m0_ack in cycle n+2, no m1 activity.
- m0 read 0x0000_0010 with dm_dout returning DEADBEEF → m0_rdata=DEADBEEF on the ack cycle, 0 otherwise.
- m0 and m1 both request DM reads continuously → grants alternate m0, m1, m0, m1. Acks are 3 cycles apart and never simultaneous.
- IO_WAIT=2, m1 write to 0x0000_7F04 → io_wr high exactly 3 cycles, m1_ack at cycle n+4. A read captures io_dout from the last strobe cycle.
- m0 access to 0x0001_0000 (unmapped) → ack+err at n+1, rdata 0, no dm/io strobes.
- rst_n pulsed low during IO_ACC → strobes drop immediately, no ack. After release the first tie goes to m0.
